// File: rtl/mult_div_unit_if.sv
// Pipeline-side bundle of the multiply/divide unit: operand request, HI/LO
// results, busy/done/stall status and a debug view of the sequencer state.
interface mult_div_unit_if #(
   parameter int DATA_W = 32
);
   logic              Start_I;
   logic [2:0]        Op_I;
   logic [DATA_W-1:0] OpA_I;
   logic [DATA_W-1:0] OpB_I;
   logic              HiLoRead_I;
   logic [DATA_W-1:0] HI_O;
   logic [DATA_W-1:0] LO_O;
   logic              Busy_O;
   logic              Done_O;
   logic              Stall_O;
   logic [1:0]        DbgState_O;

   // Pipeline drives the request; the unit answers with HI/LO and status.
   modport master (
      output Start_I, Op_I, OpA_I, OpB_I, HiLoRead_I,
      input  HI_O, LO_O, Busy_O, Done_O, Stall_O, DbgState_O
   );

   modport slave (
      input  Start_I, Op_I, OpA_I, OpB_I, HiLoRead_I,
      output HI_O, LO_O, Busy_O, Done_O, Stall_O, DbgState_O
   );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers for the MIPS-C core.
// Optional MADD/MADDU accumulate (ops 110/111) enabled by macro MDU_MADD_EN.
module mult_div_unit #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 6
) (
   input  logic            CLK_I,
   input  logic            Reset_I,
   mult_div_unit_if.slave  bus
);
   localparam int W = DATA_W;
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] FIX  = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2*W-1:0]   prod_q, prod_d;
   logic [W-1:0]     b_q, b_d;
   logic [2:0]       op_q, op_d;
   logic             negq_q, negq_d;
   logic             negr_q, negr_d;
   logic             divz_q, divz_d;
   logic [W-1:0]     hi_q, hi_d;
   logic [W-1:0]     lo_q, lo_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             op_signed, a_neg, b_neg, long_op, is_div;
   logic [W-1:0]     a_abs, b_abs;
   logic [W:0]       mul_sum;
   logic [W:0]       div_top;
   logic             div_ge;
   logic [2*W-1:0]   mul_step, div_step, mul_res, fix_res;
   logic [W-1:0]     quo, rem;

   always_comb begin
      op_signed = ~bus.Op_I[0];
      a_neg     = op_signed & bus.OpA_I[W-1];
      b_neg     = op_signed & bus.OpB_I[W-1];
      a_abs     = a_neg ? -bus.OpA_I : bus.OpA_I;
      b_abs     = b_neg ? -bus.OpB_I : bus.OpB_I;
`ifdef MDU_MADD_EN
      long_op   = ~bus.Op_I[2] | (bus.Op_I[2:1] == 2'b11);
`else
      long_op   = ~bus.Op_I[2];
`endif
      is_div    = op_q[1] & ~op_q[2];

      // prod_q holds {partial product, multiplier} or {remainder, dividend/quotient}
      mul_sum   = {1'b0, prod_q[2*W-1:W]} + {1'b0, (prod_q[0] ? b_q : {W{1'b0}})};
      mul_step  = {mul_sum, prod_q[W-1:1]};
      div_top   = {prod_q[2*W-1:W], prod_q[W-1]};
      div_ge    = (div_top >= {1'b0, b_q});
      div_step  = {(div_ge ? (div_top[W-1:0] - b_q) : div_top[W-1:0]),
                   prod_q[W-2:0], div_ge};

      mul_res   = negq_q ? -prod_q : prod_q;
      quo       = prod_q[W-1:0];
      rem       = prod_q[2*W-1:W];
      if (is_div) begin
         fix_res = {(negr_q ? -rem : rem),
                    (divz_q ? {W{1'b1}} : (negq_q ? -quo : quo))};
      end else begin
         fix_res = mul_res;
`ifdef MDU_MADD_EN
         if (op_q[2]) fix_res = {hi_q, lo_q} + mul_res;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      prod_d  = prod_q;
      b_d     = b_q;
      op_d    = op_q;
      negq_d  = negq_q;
      negr_d  = negr_q;
      divz_d  = divz_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.Start_I) begin
               if (long_op) begin
                  prod_d  = {{W{1'b0}}, a_abs};
                  b_d     = b_abs;
                  op_d    = bus.Op_I;
                  negq_d  = a_neg ^ b_neg;
                  negr_d  = a_neg;
                  divz_d  = (bus.OpB_I == {W{1'b0}});
                  cnt_d   = '0;
                  state_d = CALC;
               end else if (bus.Op_I == 3'b100) begin
                  hi_d = bus.OpA_I;
               end else if (bus.Op_I == 3'b101) begin
                  lo_d = bus.OpA_I;
               end
            end
         end
         CALC: begin
            prod_d = is_div ? div_step : mul_step;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(W - 1)) state_d = FIX;
         end
         FIX: begin
            {hi_d, lo_d} = fix_res;
            done_d       = 1'b1;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge CLK_I) begin
      if (Reset_I) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         prod_q  <= '0;
         b_q     <= '0;
         op_q    <= '0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         divz_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         prod_q  <= prod_d;
         b_q     <= b_d;
         op_q    <= op_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
         divz_q  <= divz_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.HI_O       = hi_q;
   assign bus.LO_O       = lo_q;
   assign bus.Busy_O     = busy_q;
   assign bus.Done_O     = done_q;
   assign bus.Stall_O    = busy_q & (bus.Start_I | bus.HiLoRead_I);
   assign bus.DbgState_O = state_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed plus randomized bench for mult_div_unit against an arithmetic model
// of HI/LO results; builds with or without MDU_MADD_EN.
module tb_mult_div_unit;
   logic clk = 1'b0;
   logic rst;
   int   n_vec = 0;
   int   n_err = 0;
   logic [31:0] m_hi, m_lo;
   logic [63:0] exp_q[$];

   always #5 clk = ~clk;

   mult_div_unit_if #(.DATA_W(32)) bus ();

   mult_div_unit #(.DATA_W(32), .CNT_W(6)) dut (
      .CLK_I   (clk),
      .Reset_I (rst),
      .bus     (bus)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference result {HI,LO} from plain integer arithmetic.
   function automatic logic [63:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] hilo);
      longint sa, sb, sq, sr;
      logic [63:0] ua, ub, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      r  = hilo;
      case (op)
         3'd0: r = sa * sb;
         3'd1: r = ua * ub;
         3'd2, 3'd3: begin
            if (b == 32'd0) begin
               r = {a, 32'hFFFF_FFFF};
            end else if (op == 3'd2) begin
               sq = sa / sb;
               sr = sa % sb;
               r  = {sr[31:0], sq[31:0]};
            end else begin
               r = {32'(ua % ub), 32'(ua / ub)};
            end
         end
         3'd6: r = hilo + sa * sb;
         3'd7: r = hilo + ua * ub;
         default: r = hilo;
      endcase
      return r;
   endfunction

   task automatic move_to(input logic [2:0] op, input logic [31:0] a);
      @(negedge clk);
      bus.Start_I = 1'b1; bus.Op_I = op; bus.OpA_I = a; bus.OpB_I = $urandom;
      @(negedge clk);
      bus.Start_I = 1'b0;
      if (op == 3'b100) m_hi = a; else m_lo = a;
      chk(op == 3'b100 ? "mthi" : "mtlo", {bus.HI_O, bus.LO_O}, {m_hi, m_lo});
      chk("mt_busy", 64'(bus.Busy_O), 64'd0);
   endtask

   task automatic run_long(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input bit poke);
      int cnt;
      bit held;
      logic [63:0] e;
      exp_q.push_back(ref_op(op, a, b, {m_hi, m_lo}));
      @(negedge clk);
      bus.Start_I = 1'b1; bus.Op_I = op; bus.OpA_I = a; bus.OpB_I = b;
      @(negedge clk);
      bus.Start_I = 1'b0;
      cnt = 0;
      held = 1'b1;
      while (bus.Busy_O === 1'b1 && cnt < 200) begin
         if (bus.HI_O !== m_hi || bus.LO_O !== m_lo || bus.Done_O !== 1'b0) held = 1'b0;
         if (poke && cnt == 4) begin
            bus.Start_I = 1'b1; bus.Op_I = 3'b100; bus.OpA_I = 32'hDEAD_0000;
            #1 chk("stall_start", 64'(bus.Stall_O), 64'd1);
         end
         if (poke && cnt == 5) begin
            bus.Start_I = 1'b0; bus.HiLoRead_I = 1'b1;
            #1 chk("stall_hilo", 64'(bus.Stall_O), 64'd1);
         end
         if (poke && cnt == 6) begin
            bus.HiLoRead_I = 1'b0;
            #1 chk("stall_idle_in", 64'(bus.Stall_O), 64'd0);
         end
         cnt++;
         @(negedge clk);
      end
      chk("busy_cycles", 64'(cnt), 64'd33);
      chk("hold_hilo", 64'(held), 64'd1);
      chk("done_set", 64'(bus.Done_O), 64'd1);
      bus.HiLoRead_I = 1'b1;
      #1 chk("stall_done", 64'(bus.Stall_O), 64'd0);
      bus.HiLoRead_I = 1'b0;
      e = exp_q.pop_front();
      chk("hilo", {bus.HI_O, bus.LO_O}, e);
      {m_hi, m_lo} = e;
      @(negedge clk);
      chk("done_pulse", 64'(bus.Done_O), 64'd0);
   endtask

   initial begin
      bit seen;
      logic [2:0]  op;
      logic [31:0] a, b;
      bus.Start_I = 1'b0; bus.Op_I = 3'd0; bus.OpA_I = '0; bus.OpB_I = '0;
      bus.HiLoRead_I = 1'b0;
      m_hi = '0; m_lo = '0;

      // clock/reset
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_hi", 64'(bus.HI_O), 64'd0);
      chk("rst_lo", 64'(bus.LO_O), 64'd0);
      chk("rst_busy", 64'(bus.Busy_O), 64'd0);
      chk("rst_done", 64'(bus.Done_O), 64'd0);

      // directed vectors
      run_long(3'd0, 32'hFFFF_FFFD, 32'd5, 1'b1);
      chk("mult_neg3x5", {m_hi, m_lo}, 64'hFFFF_FFFF_FFFF_FFF1);
      run_long(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      chk("multu_max", {m_hi, m_lo}, 64'hFFFF_FFFE_0000_0001);
      run_long(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
      chk("div_m7_2", {m_hi, m_lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      run_long(3'd3, 32'd100, 32'd0, 1'b0);
      chk("divu_by0", {m_hi, m_lo}, 64'h0000_0064_FFFF_FFFF);
      run_long(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      chk("div_ovf", {m_hi, m_lo}, 64'h0000_0000_8000_0000);
      run_long(3'd2, 32'hFFFF_FFF0, 32'd0, 1'b0);
      move_to(3'b100, 32'h1234_5678);
      move_to(3'b101, 32'h9ABC_DEF0);

`ifdef MDU_MADD_EN
      move_to(3'b100, 32'd0);
      move_to(3'b101, 32'hFFFF_FFFF);
      run_long(3'd7, 32'd1, 32'd1, 1'b0);
      chk("maddu_carry", {m_hi, m_lo}, 64'h0000_0001_0000_0000);
      run_long(3'd6, 32'hFFFF_FFFE, 32'd3, 1'b0);
`else
      @(negedge clk);
      bus.Start_I = 1'b1; bus.Op_I = 3'b110; bus.OpA_I = 32'd3; bus.OpB_I = 32'd4;
      @(negedge clk);
      bus.Start_I = 1'b0;
      chk("op110_busy", 64'(bus.Busy_O), 64'd0);
      @(negedge clk);
      chk("op110_done", 64'(bus.Done_O), 64'd0);
      chk("op110_hilo", {bus.HI_O, bus.LO_O}, {m_hi, m_lo});
`endif

      // randomized vectors
      repeat (20) begin
         op = 3'($urandom_range(0, 3));
         a  = $urandom;
         b  = $urandom;
         if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 9);
         if ($urandom_range(0, 5) == 0) b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
         if ($urandom_range(0, 4) == 0) move_to(3'($urandom_range(4, 5)), $urandom);
         run_long(op, a, b, 1'($urandom_range(0, 1)));
      end

      // reset in the middle of a multiply
      move_to(3'b100, 32'hAAAA_5555);
      @(negedge clk);
      bus.Start_I = 1'b1; bus.Op_I = 3'd0; bus.OpA_I = 32'd5; bus.OpB_I = 32'd7;
      @(negedge clk);
      bus.Start_I = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", 64'(bus.Busy_O), 64'd0);
      chk("abort_hi", 64'(bus.HI_O), 64'd0);
      chk("abort_lo", 64'(bus.LO_O), 64'd0);
      chk("abort_done", 64'(bus.Done_O), 64'd0);
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (bus.Done_O !== 1'b0 || bus.Busy_O !== 1'b0) seen = 1'b1;
      end
      chk("abort_quiet", 64'(seen), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit with HI/LO registers for the MIPS-C core.
- Sits directly downstream of the register file and consumes its two read ports (RData1 -> OpA_I, RData2 -> OpB_I) for MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- Produces HI/LO for MFHI/MFLO, which return to the register file write port through the writeback mux.
- Raises a stall request while a long operation is in flight.

Parameters:
- DATA_W, 32, operand/HI/LO width; iteration count equals DATA_W.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
- CLK_I  input  1  system clock; all state changes on posedge.
- Reset_I  input  1  synchronous, active-high reset.
- Start_I  input  1  op request valid this cycle.
- Op_I  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 see Optional Feature.
- OpA_I  input  DATA_W  rs operand (from RData1).
- OpB_I  input  DATA_W  rt operand (from RData2).
- HiLoRead_I  input  1  decode stage holds MFHI/MFLO.
- HI_O  output  DATA_W  HI register.
- LO_O  output  DATA_W  LO register.
- Busy_O  output  1  long operation in flight.
- Done_O  output  1  one-cycle pulse when HI/LO take a long-op result.
- Stall_O  output  1  pipeline stall request (combinational).

Behaviour:
- Reset_I=1 at a posedge:
  - state=IDLE, counter=0.
  - HI_O=0, LO_O=0, Busy_O=0, Done_O=0.
  - Any in-flight operation is aborted with no HI/LO update.
- States: IDLE, CALC, FIX. Busy_O = (state != IDLE), registered.
- IDLE:
  - Start_I=1 with Op 000-011: latch operands and op. Signed ops latch absolute values plus the result signs. Go to CALC with counter=0.
  - Start_I=1 with MTHI: HI_O<=OpA_I next edge. MTLO: LO_O<=OpA_I next edge. Stay IDLE, no Busy.
- CALC:
  - One iteration per cycle: shift-add for multiply, restoring shift-subtract for divide.
  - counter increments. After DATA_W iterations (counter==DATA_W-1 at edge) go to FIX.
- FIX:
  - Apply two's-complement sign correction. Multiply: negate the 64-bit product if signs differ. Divide: quotient negative if signs differ; remainder takes the dividend's sign.
  - Write {HI_O,LO_O} at the edge leaving FIX. Go to IDLE; Done_O=1 for exactly the following cycle.
- Latency: request accepted at edge N; Busy_O high for cycles N+1..N+DATA_W+1 (33 cycles at default); HI/LO valid and Done_O=1 in cycle N+DATA_W+2.
- Stall_O = Busy_O & (Start_I | HiLoRead_I). Start_I while Busy_O is ignored by the unit; the pipeline holds and re-presents it.
- Divide by zero: LO_O=all ones, HI_O=dividend (OpA_I as given). Always takes the full latency.
- Signed overflow (0x80000000 / -1): LO_O=0x80000000, HI_O=0.
- HI_O/LO_O hold their value during CALC/FIX; they change only on MTHI/MTLO, at the FIX exit, or on reset.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined:
  - Op 110 = MADD (signed), Op 111 = MADDU (unsigned).
  - Same multiply path and latency; at FIX exit {HI,LO} <= {HI,LO} + product (64-bit, wrap-around, no overflow flag).
  - HI/LO used in the sum are the values at FIX exit.
- Undefined: Op 110/111 with Start_I are ignored. No Busy, HI/LO unchanged, Done_O stays 0.

Test Plan:
- Reset: Reset_I=1 mid-CALC of MULT 5*7 -> next cycle Busy_O=0, HI_O=0, LO_O=0, Done_O=0, no later Done pulse.
- MULT OpA=0xFFFFFFFD (-3), OpB=5 -> Busy_O high 33 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1, Done_O one cycle.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/0 -> LO=0xFFFFFFFF, HI=0x00000064. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI 0x12345678 while idle -> HI=0x12345678 next cycle, Busy_O stays 0. Start_I or HiLoRead_I during CALC -> Stall_O=1 and the request is ignored. Stall_O=0 in the Done cycle.
- With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, then MADDU 1*1 -> HI=1, LO=0. Without the macro, Op 110 -> HI/LO unchanged, Busy_O=0.
